// File: rtl/load_store_unit.sv
// load_store_unit: initiator side of the word-addressed data-memory port.
// Accepts RV32I loads/stores over a valid/ready handshake. It drives an
// aligned word read/write port and returns extended load data with a
// one-cycle response pulse. Sub-word stores are read-modify-write.
//
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_write, req_funct3 store flag and RV32I width/sign code
//   req_addr, req_wdata   byte address, right-aligned store data
//   resp_valid            one-cycle completion pulse
//   resp_rdata/resp_error load result / fault flag, held until next response
//   mem_address           word-aligned byte address (0 when idle)
//   mem_write_data        full word to write
//   mem_write_enable      write strobe, gated low while in reset
//   mem_data              combinational read data for mem_address
module load_store_unit #(
  parameter int unsigned MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write_enable,
  input  logic [31:0] mem_data
);

  localparam int unsigned W = 32;

  typedef enum logic [2:0] {
    IDLE, LOAD, STORE, RMW_READ, RMW_WRITE, RESP
  } state_t;

  state_t      state;
  logic        mwe_q;
  logic [1:0]  lane_q;
  logic [2:0]  funct3_q;
  logic [15:0] wdata_q;   // full-word stores go straight to mem_write_data
  logic        req_err;
  logic [W-1:0] load_ext;
  logic [W-1:0] merged;
  logic [7:0]   ld_byte;
  logic [15:0]  ld_half;

  // Request classification on the incoming (unregistered) request.
  always_comb begin
    req_err = 1'b0;
    case (req_funct3)
      3'b000:         req_err = 1'b0;
      3'b001:         req_err = req_addr[0];
      3'b010:         req_err = |req_addr[1:0];
      3'b100:         req_err = req_write;
      3'b101:         req_err = req_write | req_addr[0];
      default:        req_err = 1'b1;
    endcase
    if ({2'b00, req_addr[31:2]} >= W'(MEM_WORDS)) req_err = 1'b1;
  end

  // Load lane selection and extension.
  always_comb begin
    ld_byte  = mem_data[{lane_q, 3'b000} +: 8];
    ld_half  = mem_data[{lane_q[1], 4'b0000} +: 16];
    load_ext = mem_data;
    case (funct3_q)
      3'b000:  load_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_ext = {24'd0, ld_byte};
      3'b101:  load_ext = {16'd0, ld_half};
      default: load_ext = mem_data;
    endcase
  end

  // Read-modify-write merge: replace only the addressed byte or half.
  always_comb begin
    merged = mem_data;
    if (funct3_q[0]) merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
    else             merged[{lane_q, 3'b000} +: 8]      = wdata_q[7:0];
  end

  assign mem_write_enable = mwe_q & reset_n;

  // Control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      req_ready      <= 1'b1;
      resp_valid     <= 1'b0;
      resp_rdata     <= '0;
      resp_error     <= 1'b0;
      mwe_q          <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
      lane_q         <= '0;
      funct3_q       <= '0;
      wdata_q        <= '0;
    end else begin
      resp_valid <= 1'b0;
      mwe_q      <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            lane_q    <= req_addr[1:0];
            funct3_q  <= req_funct3;
            wdata_q   <= req_wdata[15:0];
            if (req_err) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
              resp_rdata <= '0;
            end else if (!req_write) begin
              state       <= LOAD;
              mem_address <= {req_addr[31:2], 2'b00};
            end else if (req_funct3 == 3'b010) begin
              state          <= STORE;
              mem_address    <= {req_addr[31:2], 2'b00};
              mem_write_data <= req_wdata;
              mwe_q          <= 1'b1;
            end else begin
              state       <= RMW_READ;
              mem_address <= {req_addr[31:2], 2'b00};
            end
          end
        end
        LOAD: begin
          state       <= RESP;
          resp_valid  <= 1'b1;
          resp_rdata  <= load_ext;
          resp_error  <= 1'b0;
          mem_address <= '0;
        end
        RMW_READ: begin
          state          <= RMW_WRITE;
          mem_write_data <= merged;
          mwe_q          <= 1'b1;
        end
        STORE, RMW_WRITE: begin
          state       <= RESP;
          resp_valid  <= 1'b1;
          resp_rdata  <= '0;
          resp_error  <= 1'b0;
          mem_address <= '0;
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
